// File: rtl/bayes_pkg.sv
// Shared types and sizing for the Bayesian array sequencer.
// Holds the FSM state encoding, counter widths and default geometry.
package bayes_pkg;

    localparam int NARRAY_DEF     = 2;
    localparam int NWORD_DEF      = 6;
    localparam int NWORD_USED_DEF = 3;
    localparam int PIPE_LAT_DEF   = 4;

    localparam int OBS_W = 8;
    localparam int LEN_W = 16;
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        WAIT_OBS,
        INFER,
        DRAIN,
        READ,
        DONE
    } state_t;

endpackage

// File: rtl/bayes_popcnt.sv
// Per-lane saturating ones counters over the delayed stochastic window.
// The window is the inference strobe delayed by the array pipeline latency.
module bayes_popcnt
    import bayes_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        infer,
    input  logic [LANES-1:0]            bit_in,
    output logic [LANES-1:0][CNT_W-1:0] cnt
);

    logic [PIPE_LAT-1:0] win_pipe;
    logic                window;

    assign window = win_pipe[PIPE_LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            win_pipe <= '0;
            cnt      <= '0;
        end else begin
            win_pipe <= (win_pipe << 1) | PIPE_LAT'(infer);
            for (int i = 0; i < LANES; i++) begin
                if (clear) begin
                    cnt[i] <= '0;
                end else if (window && bit_in[i] && (cnt[i] != {CNT_W{1'b1}})) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/bayes_seq_ctrl.sv
// Run sequencer for the stochastic/logarithmic Bayesian inference array.
// Define BAYES_SEQ_POPCOUNT_EN to build the per-lane popcount bank behind cnt.
module bayes_seq_ctrl
    import bayes_pkg::*;
#(
    parameter int NARRAY     = NARRAY_DEF,
    parameter int NWORD      = NWORD_DEF,
    parameter int NWORD_USED = NWORD_USED_DEF,
    parameter int PIPE_LAT   = PIPE_LAT_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 cfg_mode,
    input  logic [OBS_W-1:0]                     cfg_nobs,
    input  logic [LEN_W-1:0]                     cfg_len,
    input  logic [2**NWORD_USED-1:0]             cfg_seed,
    input  logic                                 obs_valid,
    output logic                                 obs_ready,
    input  logic [NARRAY+NWORD-1:0]              obs_row,
    output logic                                 inference,
    output logic                                 load_seed,
    output logic                                 read_out,
    output logic                                 stoch_log,
    output logic [2**NWORD_USED-1:0]             seeds,
    output logic [NARRAY+NWORD-1:0]              adr_full_row,
    input  logic [2**NARRAY-1:0]                 bit_in,
    output logic                                 busy,
    output logic                                 done,
    output logic [2**NARRAY-1:0]                 result,
    output logic [2**NARRAY-1:0][CNT_W-1:0]      cnt
);

    localparam int DW = $clog2(PIPE_LAT + 1);

    state_t                  state_q;
    state_t                  state_d;
    logic                    mode_q;
    logic [OBS_W-1:0]        nobs_q;
    logic [LEN_W-1:0]        len_q;
    logic [2**NWORD_USED-1:0] seed_q;
    logic [OBS_W-1:0]        obs_cnt;
    logic [OBS_W-1:0]        obs_next;
    logic [LEN_W-1:0]        len_cnt;
    logic [LEN_W-1:0]        len_eff;
    logic [DW-1:0]           drain_cnt;
    logic                    infer_last;
    logic                    drain_last;

    assign obs_next   = obs_cnt + OBS_W'(1);
    assign len_eff    = (len_q == '0) ? LEN_W'(1) : len_q;
    assign infer_last = mode_q || (len_cnt == len_eff - LEN_W'(1));
    assign drain_last = (drain_cnt == DW'(PIPE_LAT - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start) state_d = SEED;
            SEED:     state_d = (nobs_q == '0) ? DONE : WAIT_OBS;
            WAIT_OBS: if (obs_valid) state_d = INFER;
            INFER:    if (infer_last) state_d = DRAIN;
            DRAIN:    if (drain_last) state_d = READ;
            READ:     state_d = (obs_next < nobs_q) ? WAIT_OBS : DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Array controls decode straight from the state so they stay mutually exclusive.
    always_comb begin
        load_seed = (state_q == SEED);
        inference = (state_q == INFER);
        read_out  = (state_q == READ);
        obs_ready = (state_q == WAIT_OBS);
        done      = (state_q == DONE);
        busy      = (state_q != IDLE) && (state_q != DONE);
        stoch_log = (state_q != IDLE) && mode_q;
        seeds     = (state_q == SEED) ? seed_q : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mode_q       <= 1'b0;
            nobs_q       <= '0;
            len_q        <= '0;
            seed_q       <= '0;
            obs_cnt      <= '0;
            len_cnt      <= '0;
            drain_cnt    <= '0;
            adr_full_row <= '0;
            result       <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q  <= cfg_mode;
                        nobs_q  <= cfg_nobs;
                        len_q   <= cfg_len;
                        seed_q  <= cfg_seed;
                        obs_cnt <= '0;
                    end
                end
                WAIT_OBS: begin
                    if (obs_valid) begin
                        adr_full_row <= obs_row;
                        len_cnt      <= '0;
                    end
                end
                INFER: begin
                    len_cnt   <= len_cnt + LEN_W'(1);
                    drain_cnt <= '0;
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + DW'(1);
                    if (drain_last) result <= bit_in;
                end
                READ: obs_cnt <= obs_next;
                default: ;
            endcase
        end
    end

`ifdef BAYES_SEQ_POPCOUNT_EN
    logic pc_clear;
    logic pc_infer;

    // Logarithmic runs never open the window, so their counts stay cleared.
    assign pc_clear = (state_q == WAIT_OBS) && obs_valid;
    assign pc_infer = inference && !mode_q;

    bayes_popcnt #(
        .LANES    (2**NARRAY),
        .PIPE_LAT (PIPE_LAT)
    ) u_popcnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (pc_clear),
        .infer  (pc_infer),
        .bit_in (bit_in),
        .cnt    (cnt)
    );
`else
    assign cnt = '0;
`endif

endmodule

// File: tb/tb_bayes_seq_ctrl.sv
// Scoreboard bench for bayes_seq_ctrl: stimulus pushes expectations,
// a negedge monitor pops them on read_out and done pulses.
module tb_bayes_seq_ctrl;
    import bayes_pkg::*;

    localparam int PIPE_LAT = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               cfg_mode = 1'b0;
    logic [7:0]         cfg_nobs = '0;
    logic [15:0]        cfg_len = '0;
    logic [7:0]         cfg_seed = '0;
    logic               obs_valid = 1'b0;
    logic               obs_ready;
    logic [7:0]         obs_row = '0;
    logic               inference, load_seed, read_out, stoch_log;
    logic [7:0]         seeds;
    logic [7:0]         adr_full_row;
    logic [3:0]         bit_in = '0;
    logic               busy, done;
    logic [3:0]         result;
    logic [3:0][15:0]   cnt;
    logic [26:0]        outvec;

    bayes_seq_ctrl #(
        .NARRAY(2), .NWORD(6), .NWORD_USED(3), .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_mode(cfg_mode),
        .cfg_nobs(cfg_nobs), .cfg_len(cfg_len), .cfg_seed(cfg_seed),
        .obs_valid(obs_valid), .obs_ready(obs_ready), .obs_row(obs_row),
        .inference(inference), .load_seed(load_seed), .read_out(read_out),
        .stoch_log(stoch_log), .seeds(seeds), .adr_full_row(adr_full_row),
        .bit_in(bit_in), .busy(busy), .done(done), .result(result), .cnt(cnt)
    );

    always #5 clk = ~clk;

    assign outvec = {inference, load_seed, read_out, stoch_log, seeds, adr_full_row,
                     busy, done, obs_ready, result};

    typedef struct {
        logic [3:0]  result;
        int          burst;
        logic [7:0]  adr;
        logic [63:0] cnt;
    } rd_exp_t;

    typedef struct {
        int         seeds;
        int         reads;
        int         infer;
        logic       mode;
        logic [7:0] seed;
    } run_exp_t;

    rd_exp_t  rd_q[$];
    run_exp_t run_q[$];
    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Monitor state
    int mon_burst = 0, mon_last_burst = 0, mon_drain = 0;
    int mon_seeds = 0, mon_reads = 0, mon_infer = 0, mon_excl = 0, mon_mode = 0;
    bit mon_in_drain = 0, mon_prev_inf = 0;
    logic [7:0] mon_seed_val = '0;
    rd_exp_t  mon_e;
    run_exp_t mon_r;

    task automatic monClear();
        mon_burst = 0; mon_last_burst = 0; mon_drain = 0;
        mon_seeds = 0; mon_reads = 0; mon_infer = 0; mon_excl = 0; mon_mode = 0;
        mon_in_drain = 0; mon_prev_inf = 0; mon_seed_val = '0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            rd_q.delete();
            run_q.delete();
            monClear();
        end else begin
            if (int'(load_seed) + int'(inference) + int'(read_out) > 1) mon_excl++;
            if (obs_ready && (load_seed || inference || read_out || done)) mon_excl++;
            if (busy && run_q.size() > 0 && stoch_log !== run_q[0].mode) mon_mode++;
            if (!busy && !done && stoch_log) mon_mode++;
            if (load_seed) begin
                mon_seeds++;
                mon_seed_val = seeds;
            end
            if (inference) begin
                mon_burst++;
                mon_infer++;
            end else if (mon_prev_inf) begin
                mon_last_burst = mon_burst;
                mon_burst = 0;
                mon_in_drain = 1;
                mon_drain = 0;
            end
            if (mon_in_drain && !read_out && !inference) mon_drain++;
            mon_prev_inf = inference;

            if (read_out) begin
                mon_reads++;
                mon_in_drain = 0;
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL read_unexpected: read_out with no pending observation");
                end else begin
                    mon_e = rd_q.pop_front();
                    checkOutput("result", 64'(result), 64'(mon_e.result));
                    checkOutput("burst_len", 64'(mon_last_burst), 64'(mon_e.burst));
                    checkOutput("drain_len", 64'(mon_drain), 64'(PIPE_LAT));
                    checkOutput("adr_full_row", 64'(adr_full_row), 64'(mon_e.adr));
                    checkOutput("cnt", cnt, mon_e.cnt);
                end
            end

            if (done) begin
                if (run_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL done_unexpected: done with no pending run");
                end else begin
                    mon_r = run_q.pop_front();
                    checkOutput("seed_pulses", 64'(mon_seeds), 64'(mon_r.seeds));
                    checkOutput("seed_value", 64'(mon_seed_val), 64'(mon_r.seed));
                    checkOutput("read_pulses", 64'(mon_reads), 64'(mon_r.reads));
                    checkOutput("infer_cycles", 64'(mon_infer), 64'(mon_r.infer));
                    checkOutput("ctrl_exclusive", 64'(mon_excl), 64'(0));
                    checkOutput("stoch_log_track", 64'(mon_mode), 64'(0));
                    checkOutput("done_busy", 64'(busy), 64'(0));
                    checkOutput("done_stoch_log", 64'(stoch_log), 64'(mon_r.mode));
                    checkOutput("pending_reads", 64'(rd_q.size()), 64'(0));
                end
                monClear();
            end
        end
    end

    task automatic waitReady(output bit ok);
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            if (obs_ready) begin
                ok = 1;
                return;
            end
            tick();
        end
        checkOutput("ready_timeout", 64'(obs_ready), 64'(1));
    endtask

    task automatic waitDone();
        for (int k = 0; k < 2000; k++) begin
            if (done) begin
                tick();
                return;
            end
            tick();
        end
        checkOutput("done_timeout", 64'(done), 64'(1));
    endtask

    task automatic applyStimulus(input logic mode, input logic [7:0] nobs, input logic [15:0] len,
                                 input logic [7:0] seed, input logic [3:0] bits0,
                                 input int obs_delay, input bit poke_start);
        int       burst;
        run_exp_t r;
        rd_exp_t  e;
        bit       ok;
        burst = (mode || len == 16'd0) ? 1 : int'(len);
        r.seeds = 1;
        r.reads = int'(nobs);
        r.infer = int'(nobs) * burst;
        r.mode  = mode;
        r.seed  = seed;
        run_q.push_back(r);
        start = 1'b1; cfg_mode = mode; cfg_nobs = nobs; cfg_len = len; cfg_seed = seed;
        tick();
        start = 1'b0;
        for (int i = 0; i < int'(nobs); i++) begin
            waitReady(ok);
            if (!ok) return;
            if (i == 0) begin
                for (int d = 0; d < obs_delay; d++) begin
                    checkOutput("wait_obs_hold", 64'({obs_ready, load_seed, inference, read_out}),
                                64'(4'b1000));
                    tick();
                end
            end
            e.adr    = seed + 8'(i * 33);
            e.result = bits0 ^ 4'(i * 5);
            e.burst  = burst;
            e.cnt    = '0;
`ifdef BAYES_SEQ_POPCOUNT_EN
            for (int l = 0; l < 4; l++)
                if (!mode && e.result[l]) e.cnt[l*16 +: 16] = 16'(burst);
`endif
            rd_q.push_back(e);
            obs_valid = 1'b1;
            obs_row   = e.adr;
            bit_in    = e.result;
            if (poke_start) start = 1'b1;
            tick();
            obs_valid = 1'b0;
            start     = 1'b0;
        end
        waitDone();
    endtask

    initial begin
        bit ok;
        $display("[TB] reset");
        tick();
        tick();
        checkOutput("reset_outputs", 64'(outvec), 64'(0));
        checkOutput("reset_cnt", cnt, 64'(0));
        rst = 1'b0;
        tick();

        $display("[TB] stochastic run nobs=2 len=8");
        applyStimulus(1'b0, 8'd2, 16'd8, 8'hA5, 4'b1010, 0, 1'b1);

        $display("[TB] logarithmic run nobs=3");
        applyStimulus(1'b1, 8'd3, 16'd8, 8'h3C, 4'b0011, 0, 1'b0);

        $display("[TB] nobs=0 run");
        applyStimulus(1'b0, 8'd0, 16'd8, 8'h5A, 4'b0000, 0, 1'b0);

        $display("[TB] delayed observation, len=0");
        applyStimulus(1'b0, 8'd1, 16'd0, 8'hC3, 4'b1001, 5, 1'b0);

        $display("[TB] reset during inference");
        start = 1'b1; cfg_mode = 1'b0; cfg_nobs = 8'd1; cfg_len = 16'd20; cfg_seed = 8'h77;
        tick();
        start = 1'b0;
        waitReady(ok);
        if (ok) begin
            obs_valid = 1'b1;
            obs_row   = 8'h99;
            tick();
            obs_valid = 1'b0;
            repeat (3) tick();
            checkOutput("mid_infer_active", 64'(inference), 64'(1));
            rst = 1'b1;
            tick();
            rst = 1'b0;
            checkOutput("rst_mid_infer", 64'(outvec), 64'(0));
            checkOutput("rst_mid_infer_cnt", cnt, 64'(0));
        end
        tick();

        $display("[TB] stochastic run len=16 bit_in=0101");
        applyStimulus(1'b0, 8'd1, 16'd16, 8'h81, 4'b0101, 0, 1'b0);

        repeat (3) tick();
        checkOutput("final_idle", 64'({busy, obs_ready, inference}), 64'(0));
        checkOutput("runs_drained", 64'(run_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bayes_seq_ctrl.md
BAYES_SEQ_CTRL -- requirements
Module: bayes_seq_ctrl

Interface
REQ-001 Parameter NARRAY, default 2, log2 of likelihood array rows/columns.
REQ-002 Parameter NWORD, default 6, log2 of words per memory.
REQ-003 Parameter NWORD_USED, default 3, log2 of random/data bus width.
REQ-004 Parameter PIPE_LAT, default 4, cycles from first inference cycle to first valid bit_in.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  begin one run; sampled only in IDLE.
REQ-008 cfg_mode  in  1  0 stochastic, 1 logarithmic; latched at start.
REQ-009 cfg_nobs  in  8  observations per run; 0 means skip directly to DONE.
REQ-010 cfg_len  in  16  stochastic stream length in cycles; 0 treated as 1.
REQ-011 cfg_seed  in  2**NWORD_USED  LFSR seed; latched at start.
REQ-012 obs_valid / obs_ready / obs_row  in/out/in  1/1/NARRAY+NWORD  observation row-address handshake.
REQ-013 inference, load_seed, read_out, stoch_log  out  1 each  array controls.
REQ-014 seeds  out  2**NWORD_USED; adr_full_row  out  NARRAY+NWORD.
REQ-015 bit_in  in  2**NARRAY  array bit_out.
REQ-016 busy, done  out  1; result  out  2**NARRAY  last captured bit_in.

Function
REQ-017 States SHALL be IDLE, SEED, WAIT_OBS, INFER, DRAIN, READ, DONE.
REQ-018 IDLE: start=1 latches cfg, sets busy=1, goes to SEED next cycle.
REQ-019 SEED: load_seed=1 and seeds=latched seed for exactly one cycle; then WAIT_OBS, or DONE if nobs=0.
REQ-020 WAIT_OBS: obs_ready=1; on obs_valid&obs_ready, obs_row SHALL be registered onto adr_full_row and the state SHALL become INFER.
REQ-021 INFER: inference=1 for cfg_len cycles (stochastic) or exactly 1 cycle (logarithmic); adr_full_row held stable.
REQ-022 DRAIN: inference=0 for PIPE_LAT cycles; bit_in sampled at the last DRAIN cycle into result.
REQ-023 READ: read_out=1 for one cycle; obs counter increments; next WAIT_OBS if count<nobs, else DONE.
REQ-024 DONE: done=1 for exactly one cycle, busy=0 in that cycle, then IDLE.
REQ-025 stoch_log SHALL equal the latched mode from SEED to DONE inclusive, 0 in IDLE.
REQ-026 obs_ready SHALL be 0 outside WAIT_OBS; start outside IDLE SHALL be ignored.
REQ-027 Obs counter 8 bits, length counter 16 bits; no wrap possible since nobs ≤ 255 and cfg_len ≤ 65535.
REQ-028 load_seed, inference, read_out SHALL be mutually exclusive in every cycle.

Reset
REQ-029 rst SHALL force IDLE in the next cycle from any state, including mid-INFER.
REQ-030 Reset values: all control outputs 0, seeds 0, adr_full_row 0, result 0, busy 0, done 0, obs_ready 0, counters 0.

Configuration
REQ-031 Macro BAYES_SEQ_POPCOUNT_EN: when defined, output cnt[2**NARRAY] of 16 bits each counts ones per bit_in lane during the stochastic window (PIPE_LAT after inference rise, cfg_len cycles), cleared on entering INFER, held until next INFER.
REQ-032 Without BAYES_SEQ_POPCOUNT_EN the cnt port SHALL exist and be driven constant 0; no counter logic is synthesised.
REQ-033 In logarithmic mode cnt SHALL remain 0 regardless of the macro.

Structure
REQ-034 State enum, counter widths and the default parameters SHALL live in package bayes_pkg.
REQ-035 One sub-module bayes_popcnt (per-lane saturating counter bank) SHALL be instantiated only under the macro.

Verification
REQ-036 Stochastic run: mode=0, nobs=2, len=8, two obs -> one load_seed pulse, two 8-cycle inference bursts, two read_out pulses, done pulse.
REQ-037 Log run: mode=1, nobs=3 -> three 1-cycle inference pulses, stoch_log=1 throughout busy.
REQ-038 nobs=0 -> SEED then DONE; no inference or read_out pulses.
REQ-039 obs_valid delayed 5 cycles -> controller holds WAIT_OBS with obs_ready=1, all array controls 0.
REQ-040 rst asserted mid-INFER -> next cycle IDLE, all outputs at reset values; a subsequent start runs normally.
REQ-041 Popcount (macro on): bit_in=4'b0101 constant, len=16 -> cnt = {0,16,0,16}.
